// File: rtl/change_arbiter.sv
// Two-vendor change dispenser: round-robin grant, greedy 10/1 coin payout
// with hopper stock tracking, dispenser handshake and jam timeout.
module change_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] amount0,
    input  logic [WIDTH-1:0] amount1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [1:0]       short,
    output logic             ten_drop,
    output logic             one_drop,
    input  logic             drop_ack,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_ten,
    input  logic [WIDTH-1:0] load_one,
    output logic [WIDTH-1:0] remaining,
    output logic [WIDTH-1:0] ten_stock,
    output logic [WIDTH-1:0] one_stock,
    output logic             busy,
    output logic             fault
);

    typedef enum logic [2:0] {
        IDLE, DECIDE, DROP, WAIT, DONE, SHORT, FAULT
    } state_t;

    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] TEN      = WIDTH'(10);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state, state_n;
    logic [1:0]       grant_q;
    logic [1:0]       grant_pick;
    logic             rr_q;          // 1: vendor 1 wins a tie next time
    logic             coin_ten_q, coin_ten_n;
    logic [WIDTH-1:0] remaining_q;
    logic [WIDTH-1:0] ten_q, one_q;
    logic [TW-1:0]    tmo_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        coin_ten_n = coin_ten_q;
        grant_pick = 2'b00;
        case (state)
            IDLE: begin
                if (req[0] && (!req[1] || !rr_q))
                    grant_pick = 2'b01;
                else if (req[1])
                    grant_pick = 2'b10;
                if (grant_pick != 2'b00)
                    state_n = DECIDE;
            end
            DECIDE: begin
                if (remaining_q == '0) begin
                    state_n = DONE;
                end else if (remaining_q >= TEN && ten_q != '0) begin
                    state_n    = DROP;
                    coin_ten_n = 1'b1;
                end else if (one_q != '0) begin
                    state_n    = DROP;
                    coin_ten_n = 1'b0;
                end else begin
                    state_n = SHORT;
                end
            end
            DROP:  state_n = WAIT;
            WAIT: begin
                if (drop_ack)
                    state_n = DECIDE;
                else if (tmo_q == TMO_LAST)
                    state_n = FAULT;
            end
            DONE:    state_n = IDLE;
            SHORT:   state_n = IDLE;
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            rr_q        <= 1'b0;
            coin_ten_q  <= 1'b0;
            remaining_q <= '0;
            ten_q       <= '0;
            one_q       <= '0;
            tmo_q       <= '0;
        end else begin
            coin_ten_q <= coin_ten_n;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        ten_q <= load_ten;
                        one_q <= load_one;
                    end
                    if (grant_pick != 2'b00) begin
                        grant_q     <= grant_pick;
                        rr_q        <= grant_pick[0];
                        remaining_q <= grant_pick[0] ? amount0 : amount1;
                    end
                end
                DROP: tmo_q <= '0;
                WAIT: begin
                    if (drop_ack) begin
                        // DECIDE already guaranteed stock>0; guards keep counters from wrapping.
                        if (coin_ten_q) begin
                            remaining_q <= remaining_q - TEN;
                            if (ten_q != '0) ten_q <= ten_q - ONE;
                        end else begin
                            remaining_q <= remaining_q - ONE;
                            if (one_q != '0) one_q <= one_q - ONE;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DONE, SHORT: grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = (state == DONE)  ? grant_q : 2'b00;
    assign short     = (state == SHORT) ? grant_q : 2'b00;
    assign ten_drop  = (state == DROP) &&  coin_ten_q;
    assign one_drop  = (state == DROP) && !coin_ten_q;
    assign remaining = remaining_q;
    assign ten_stock = ten_q;
    assign one_stock = one_q;
    assign busy      = (state != IDLE);
    assign fault     = (state == FAULT);

endmodule

// File: tb/tb_change_arbiter.sv
// Directed self-checking bench for change_arbiter; outputs sampled on the
// falling edge, inputs driven on the falling edge.
module tb_change_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] amount0, amount1;
    logic [1:0]       grant, done, short;
    logic             ten_drop, one_drop, drop_ack;
    logic             load_en;
    logic [WIDTH-1:0] load_ten, load_one;
    logic [WIDTH-1:0] remaining, ten_stock, one_stock;
    logic             busy, fault;

    int checks   = 0;
    int failures = 0;

    int         n_ten, n_one, n_bad_grant;
    logic [1:0] done_seen, short_seen;
    logic       finished;
    logic [7:0] coin_order;

    always #5 clk = ~clk;

    change_arbiter #(.WIDTH(WIDTH), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .amount0(amount0), .amount1(amount1),
        .grant(grant), .done(done), .short(short),
        .ten_drop(ten_drop), .one_drop(one_drop), .drop_ack(drop_ack),
        .load_en(load_en), .load_ten(load_ten), .load_one(load_one),
        .remaining(remaining), .ten_stock(ten_stock), .one_stock(one_stock),
        .busy(busy), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_ctl"},  32'({grant, done, short, ten_drop, one_drop, busy, fault}), 0);
        check({tag, "_rem"},  32'(remaining), 0);
        check({tag, "_stk"},  32'({ten_stock, one_stock}), 0);
    endtask

    // Runs one payout to its done/short pulse, acking each drop one cycle later.
    task automatic run_service(input int max_cycles);
        logic pending = 1'b0;
        n_ten = 0; n_one = 0; n_bad_grant = 0;
        done_seen = '0; short_seen = '0; finished = 1'b0; coin_order = '0;
        for (int i = 0; i < max_cycles && !finished; i++) begin
            step();
            drop_ack = pending;
            pending  = ten_drop | one_drop;
            if (ten_drop) begin n_ten++; coin_order = {coin_order[6:0], 1'b1}; end
            if (one_drop) begin n_one++; coin_order = {coin_order[6:0], 1'b0}; end
            if (grant == 2'b11) n_bad_grant++;
            if (done != '0 || short != '0) begin
                done_seen  = done;
                short_seen = short;
                finished   = 1'b1;
                req        = '0;
            end
        end
        drop_ack = 1'b0;
        check("svc_finished", 32'(finished), 1);
    endtask

    initial begin
        rst = 1'b1; req = '0; amount0 = '0; amount1 = '0; drop_ack = 1'b0;
        load_en = 1'b0; load_ten = '0; load_one = '0;
        step(); step();
        all_zero("reset");
        rst = 1'b0;
        step();
        all_zero("idle");

        // Basic payout of 12 from 5/5: ten, one, one.
        load_en = 1'b1; load_ten = 8'd5; load_one = 8'd5;
        step();
        load_en = 1'b0;
        check("t1_stock", 32'({ten_stock, one_stock}), 32'({8'd5, 8'd5}));
        req = 2'b01; amount0 = 8'd12;
        step();
        check("t1_grant", 32'(grant), 32'(2'b01));
        check("t1_rem0",  32'(remaining), 12);
        check("t1_busy",  32'(busy), 1);
        run_service(60);
        check("t1_nten",  32'(n_ten), 1);
        check("t1_none",  32'(n_one), 2);
        check("t1_order", 32'(coin_order[2:0]), 32'(3'b100));
        check("t1_done",  32'(done_seen), 32'(2'b01));
        check("t1_short", 32'(short_seen), 0);
        check("t1_rem",   32'(remaining), 0);
        check("t1_stk",   32'({ten_stock, one_stock}), 32'({8'd4, 8'd3}));
        step();
        check("t1_idle",  32'({grant, busy}), 0);

        // Tie after reset: vendor 0 first, then vendor 1; zero amount -> done two cycles after req.
        rst = 1'b1; step(); rst = 1'b0;
        req = 2'b11; amount0 = 8'd0; amount1 = 8'd0;
        step();
        check("t2_g0",    32'(grant), 32'(2'b01));
        check("t2_nodrop0", 32'({ten_drop, one_drop, done}), 0);
        step();
        check("t2_done0", 32'(done), 32'(2'b01));
        check("t2_nodrop1", 32'({ten_drop, one_drop}), 0);
        step();
        check("t2_gap",   32'(grant), 0);
        step();
        check("t2_g1",    32'(grant), 32'(2'b10));
        step();
        check("t2_done1", 32'(done), 32'(2'b10));
        req = '0;
        step();
        check("t2_idle",  32'({grant, done, busy}), 0);

        // Load coincides with req; only ones available -> short with 9 unpaid.
        load_en = 1'b1; load_ten = 8'd0; load_one = 8'd3;
        req = 2'b10; amount1 = 8'd12;
        step();
        load_en = 1'b0;
        check("t3_grant", 32'(grant), 32'(2'b10));
        check("t3_stk0",  32'({ten_stock, one_stock}), 32'({8'd0, 8'd3}));
        run_service(60);
        check("t3_nten",  32'(n_ten), 0);
        check("t3_none",  32'(n_one), 3);
        check("t3_short", 32'(short_seen), 32'(2'b10));
        check("t3_done",  32'(done_seen), 0);
        check("t3_rem",   32'(remaining), 9);
        check("t3_gbad",  32'(n_bad_grant), 0);
        step();
        check("t3_hold",  32'({grant, remaining}), 32'({2'b00, 8'd9}));
        check("t3_stk",   32'({ten_stock, one_stock}), 0);

        // load_en ignored in WAIT; reset in WAIT clears everything.
        load_en = 1'b1; load_ten = 8'd5; load_one = 8'd5;
        step();
        load_en = 1'b0;
        req = 2'b01; amount0 = 8'd3;
        step();
        step();
        check("t4_onedrop", 32'({ten_drop, one_drop}), 32'(2'b01));
        step();
        load_en = 1'b1; load_ten = 8'd9; load_one = 8'd9;
        step();
        load_en = 1'b0;
        check("t4_stk",   32'({ten_stock, one_stock}), 32'({8'd5, 8'd5}));
        check("t4_busy",  32'(busy), 1);
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0;
        all_zero("t4_rst");

        // Ack during DROP ignored; ack withheld 15 cycles in WAIT -> sticky fault.
        load_en = 1'b1; load_ten = 8'd5; load_one = 8'd5;
        step();
        load_en = 1'b0;
        req = 2'b01; amount0 = 8'd1;
        step();
        step();
        check("t5_drop",  32'(one_drop), 1);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
        check("t5_ign",   32'({remaining, one_stock}), 32'({8'd1, 8'd5}));
        req = '0;
        repeat (14) step();
        check("t5_prefault", 32'({fault, busy}), 32'(2'b01));
        step();
        check("t5_fault", 32'({fault, busy}), 32'(2'b11));
        drop_ack = 1'b1;
        repeat (5) step();
        drop_ack = 1'b0;
        check("t5_sticky", 32'({fault, busy, remaining}), 32'({2'b11, 8'd1}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        all_zero("t5_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
